audio_i2s_bridge: RTL and testbench

AUDIO_I2S_BRIDGE -- requirements
Module: audio_i2s_bridge

---
 rtl/audio_i2s_bridge.sv | 248 ++++++++++++++++++++++++
 tb/tb_audio_i2s_bridge.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_bridge.sv
// I2S slave bridge between a codec (bus master) and Avalon-ST left/right streams.
// Define AUDIO_BRIDGE_STATUS_EN to enable the saturating overrun/underrun counters.
`timescale 1ns / 1ps
module audio_i2s_bridge #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_aud_bclk,
    input  logic             i_aud_adclrck,
    input  logic             i_aud_daclrck,
    input  logic             i_aud_adcdat,
    output logic             o_aud_dacdat,
    output logic [WIDTH-1:0] o_adc_left_data,
    output logic [WIDTH-1:0] o_adc_right_data,
    output logic             o_adc_left_valid,
    output logic             o_adc_right_valid,
    input  logic             i_adc_left_ready,
    input  logic             i_adc_right_ready,
    input  logic [WIDTH-1:0] i_dac_left_data,
    input  logic [WIDTH-1:0] i_dac_right_data,
    input  logic             i_dac_left_valid,
    input  logic             i_dac_right_valid,
    output logic             o_dac_left_ready,
    output logic             o_dac_right_ready,
    output logic             o_rx_overrun,
    output logic             o_tx_underrun,
    output logic [7:0]       o_rx_overrun_cnt,
    output logic [7:0]       o_tx_underrun_cnt
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {RX_WAIT, RX_SKIP, RX_SHIFT, RX_STORE} rx_state_t;

    logic [2:0] bclk_sync, adlr_sync, dalr_sync, prime_q;
    logic [1:0] adcdat_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bclk_sync   <= '0;
            adlr_sync   <= '0;
            dalr_sync   <= '0;
            adcdat_sync <= '0;
            prime_q     <= '0;
        end else begin
            bclk_sync   <= {bclk_sync[1:0], i_aud_bclk};
            adlr_sync   <= {adlr_sync[1:0], i_aud_adclrck};
            dalr_sync   <= {dalr_sync[1:0], i_aud_daclrck};
            adcdat_sync <= {adcdat_sync[0], i_aud_adcdat};
            prime_q     <= {prime_q[1:0], 1'b1};
        end
    end

    // Edges are masked until the synchronizers hold real samples, so reset release
    // never fakes an LRCK edge.
    logic bclk_rise, bclk_fall, adlr_edge, dalr_edge, adlr_lvl, dalr_lvl, adcdat_s;
    assign bclk_rise = prime_q[2] & bclk_sync[1] & ~bclk_sync[2];
    assign bclk_fall = prime_q[2] & ~bclk_sync[1] & bclk_sync[2];
    assign adlr_edge = prime_q[2] & (adlr_sync[1] ^ adlr_sync[2]);
    assign dalr_edge = prime_q[2] & (dalr_sync[1] ^ dalr_sync[2]);
    assign adlr_lvl  = adlr_sync[1];
    assign dalr_lvl  = dalr_sync[1];
    assign adcdat_s  = adcdat_sync[1];

    rx_state_t        rx_state_q, rx_state_d;
    logic             rx_chan_q, rx_chan_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
    logic             rx_store;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_state_q <= RX_WAIT;
            rx_chan_q  <= 1'b0;
            rx_sh_q    <= '0;
            rx_cnt_q   <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_chan_q  <= rx_chan_d;
            rx_sh_q    <= rx_sh_d;
            rx_cnt_q   <= rx_cnt_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_chan_d  = rx_chan_q;
        rx_sh_d    = rx_sh_q;
        rx_cnt_d   = rx_cnt_q;
        rx_store   = 1'b0;
        unique case (rx_state_q)
            RX_WAIT: begin
                if (adlr_edge) begin
                    rx_state_d = RX_SKIP;
                    rx_chan_d  = adlr_lvl;
                end
            end
            RX_SKIP: begin
                if (adlr_edge) begin
                    rx_chan_d = adlr_lvl;
                end else if (bclk_rise) begin
                    rx_state_d = RX_SHIFT;
                    rx_cnt_d   = '0;
                end
            end
            RX_SHIFT: begin
                if (adlr_edge) begin
                    rx_state_d = RX_SKIP;
                    rx_chan_d  = adlr_lvl;
                end else if (bclk_rise) begin
                    rx_sh_d  = {rx_sh_q[WIDTH-2:0], adcdat_s};
                    rx_cnt_d = rx_cnt_q + 1'b1;
                    if (rx_cnt_q == CW'(WIDTH - 1)) rx_state_d = RX_STORE;
                end
            end
            RX_STORE: begin
                rx_store = 1'b1;
                // An edge landing on the store cycle starts the next half-frame directly.
                if (adlr_edge) begin
                    rx_state_d = RX_SKIP;
                    rx_chan_d  = adlr_lvl;
                end else begin
                    rx_state_d = RX_WAIT;
                end
            end
            default: rx_state_d = RX_WAIT;
        endcase
    end

    logic [WIDTH-1:0] left_data_q, right_data_q;
    logic             left_valid_q, right_valid_q, overrun_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            left_data_q   <= '0;
            right_data_q  <= '0;
            left_valid_q  <= 1'b0;
            right_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (left_valid_q && i_adc_left_ready)   left_valid_q  <= 1'b0;
            if (right_valid_q && i_adc_right_ready) right_valid_q <= 1'b0;
            if (rx_store && !rx_chan_q) begin
                if (left_valid_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    left_data_q  <= rx_sh_q;
                    left_valid_q <= 1'b1;
                end
            end
            if (rx_store && rx_chan_q) begin
                if (right_valid_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    right_data_q  <= rx_sh_q;
                    right_valid_q <= 1'b1;
                end
            end
        end
    end

    logic [WIDTH-1:0] tx_buf_l_q, tx_buf_r_q, tx_sh_q;
    logic             tx_full_l_q, tx_full_r_q, alive_q, dacdat_q, underrun_q;
    logic [CW-1:0]    tx_cnt_q;
    logic             dac_left_acc, dac_right_acc;

    assign dac_left_acc  = i_dac_left_valid & o_dac_left_ready;
    assign dac_right_acc = i_dac_right_valid & o_dac_right_ready;

    // Buffer load happens before accept so a same-cycle free and write ends full.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_buf_l_q  <= '0;
            tx_buf_r_q  <= '0;
            tx_full_l_q <= 1'b0;
            tx_full_r_q <= 1'b0;
            tx_sh_q     <= '0;
            tx_cnt_q    <= '0;
            alive_q     <= 1'b0;
            dacdat_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            alive_q    <= 1'b1;
            underrun_q <= 1'b0;
            if (dalr_edge) begin
                tx_cnt_q <= CW'(WIDTH);
                if (dalr_lvl) begin
                    tx_sh_q     <= tx_full_r_q ? tx_buf_r_q : '0;
                    underrun_q  <= ~tx_full_r_q;
                    tx_full_r_q <= 1'b0;
                end else begin
                    tx_sh_q     <= tx_full_l_q ? tx_buf_l_q : '0;
                    underrun_q  <= ~tx_full_l_q;
                    tx_full_l_q <= 1'b0;
                end
            end else if (bclk_fall) begin
                if (tx_cnt_q != '0) begin
                    dacdat_q <= tx_sh_q[WIDTH-1];
                    tx_sh_q  <= {tx_sh_q[WIDTH-2:0], 1'b0};
                    tx_cnt_q <= tx_cnt_q - 1'b1;
                end else begin
                    dacdat_q <= 1'b0;
                end
            end
            if (dac_left_acc) begin
                tx_buf_l_q  <= i_dac_left_data;
                tx_full_l_q <= 1'b1;
            end
            if (dac_right_acc) begin
                tx_buf_r_q  <= i_dac_right_data;
                tx_full_r_q <= 1'b1;
            end
        end
    end

    assign o_aud_dacdat      = dacdat_q;
    assign o_adc_left_data   = left_data_q;
    assign o_adc_right_data  = right_data_q;
    assign o_adc_left_valid  = left_valid_q;
    assign o_adc_right_valid = right_valid_q;
    assign o_dac_left_ready  = alive_q & ~tx_full_l_q;
    assign o_dac_right_ready = alive_q & ~tx_full_r_q;
    assign o_rx_overrun      = overrun_q;
    assign o_tx_underrun     = underrun_q;

`ifdef AUDIO_BRIDGE_STATUS_EN
    logic [7:0] ovr_cnt_q, und_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovr_cnt_q <= '0;
            und_cnt_q <= '0;
        end else begin
            if (overrun_q && ovr_cnt_q != 8'hFF)  ovr_cnt_q <= ovr_cnt_q + 8'd1;
            if (underrun_q && und_cnt_q != 8'hFF) und_cnt_q <= und_cnt_q + 8'd1;
        end
    end

    assign o_rx_overrun_cnt  = ovr_cnt_q;
    assign o_tx_underrun_cnt = und_cnt_q;
`else
    assign o_rx_overrun_cnt  = '0;
    assign o_tx_underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_audio_i2s_bridge.sv
// Directed bench for audio_i2s_bridge: drives an I2S codec model and checks both stream paths.
`timescale 1ns / 1ps
module tb_audio_i2s_bridge;

    localparam int HB = 20;  // BCLK periods per half-frame
`ifdef AUDIO_BRIDGE_STATUS_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        i_clk, i_rst_n;
    logic        i_aud_bclk, i_aud_adclrck, i_aud_daclrck, i_aud_adcdat, o_aud_dacdat;
    logic [15:0] o_adc_left_data, o_adc_right_data, i_dac_left_data, i_dac_right_data;
    logic        o_adc_left_valid, o_adc_right_valid, i_adc_left_ready, i_adc_right_ready;
    logic        i_dac_left_valid, i_dac_right_valid, o_dac_left_ready, o_dac_right_ready;
    logic        o_rx_overrun, o_tx_underrun;
    logic [7:0]  o_rx_overrun_cnt, o_tx_underrun_cnt;

    audio_i2s_bridge #(.WIDTH(16)) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_aud_bclk        (i_aud_bclk),
        .i_aud_adclrck     (i_aud_adclrck),
        .i_aud_daclrck     (i_aud_daclrck),
        .i_aud_adcdat      (i_aud_adcdat),
        .o_aud_dacdat      (o_aud_dacdat),
        .o_adc_left_data   (o_adc_left_data),
        .o_adc_right_data  (o_adc_right_data),
        .o_adc_left_valid  (o_adc_left_valid),
        .o_adc_right_valid (o_adc_right_valid),
        .i_adc_left_ready  (i_adc_left_ready),
        .i_adc_right_ready (i_adc_right_ready),
        .i_dac_left_data   (i_dac_left_data),
        .i_dac_right_data  (i_dac_right_data),
        .i_dac_left_valid  (i_dac_left_valid),
        .i_dac_right_valid (i_dac_right_valid),
        .o_dac_left_ready  (o_dac_left_ready),
        .o_dac_right_ready (o_dac_right_ready),
        .o_rx_overrun      (o_rx_overrun),
        .o_tx_underrun     (o_tx_underrun),
        .o_rx_overrun_cnt  (o_rx_overrun_cnt),
        .o_tx_underrun_cnt (o_tx_underrun_cnt)
    );

    logic [63:0] all_outs;
    assign all_outs = {9'd0, o_adc_left_data, o_adc_right_data, o_adc_left_valid,
                       o_adc_right_valid, o_dac_left_ready, o_dac_right_ready, o_rx_overrun,
                       o_tx_underrun, o_rx_overrun_cnt, o_tx_underrun_cnt, o_aud_dacdat};

    // Clock edges sit off the 20 ns grid the codec model drives on.
    initial begin
        i_clk = 1'b0;
        #2;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    int          uf_pulses = 0, ov_pulses = 0, lv_cycles = 0;
    logic [15:0] left_q[$], right_q[$];

    always @(negedge i_clk) begin
        if (o_tx_underrun) uf_pulses <= uf_pulses + 1;
        if (o_rx_overrun) ov_pulses <= ov_pulses + 1;
        if (o_adc_left_valid) lv_cycles <= lv_cycles + 1;
        if (o_adc_left_valid && i_adc_left_ready) left_q.push_back(o_adc_left_data);
        if (o_adc_right_valid && i_adc_right_ready) right_q.push_back(o_adc_right_data);
    end

    task automatic align20();
        if ($time % 20 != 0) #(20 - ($time % 20));
    endtask

    // One I2S half-frame: LRCK and data change on BCLK falling edges, MSB one BCLK late.
    task automatic half_frame(input logic lr, input logic [15:0] adc_w, input int rst_at,
                              output logic [15:0] dac_w, output logic tail_zero);
        dac_w     = '0;
        tail_zero = 1'b1;
        for (int b = 0; b < HB; b++) begin
            i_aud_bclk = 1'b0;
            if (b == 0) begin
                i_aud_adclrck = lr;
                i_aud_daclrck = lr;
            end
            if (b == rst_at) i_rst_n = 1'b0;
            if (b == rst_at + 2) i_rst_n = 1'b1;
            i_aud_adcdat = (b >= 1 && b <= 16) ? adc_w[16-b] : 1'b0;
            #20 i_aud_bclk = 1'b1;
            #18;
            if (b == rst_at + 1) check_val("rst_mid_outs", all_outs, 64'd0);
            if (b >= 1 && b <= 16) dac_w[16-b] = o_aud_dacdat;
            else if (o_aud_dacdat) tail_zero = 1'b0;
            #2;
        end
    endtask

    task automatic do_reset();
        align20();
        i_rst_n = 1'b0;
        #100;
        i_rst_n = 1'b1;
        #100;
    endtask

    task automatic dac_write(input logic right, input logic [15:0] d);
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge i_clk);
            ok = right ? o_dac_right_ready : o_dac_left_ready;
        end
        check_val("wr_ready_seen", 64'(ok), 64'd1);
        if (right) begin
            i_dac_right_data  = d;
            i_dac_right_valid = 1'b1;
        end else begin
            i_dac_left_data  = d;
            i_dac_left_valid = 1'b1;
        end
        @(negedge i_clk);
        i_dac_left_valid  = 1'b0;
        i_dac_right_valid = 1'b0;
    endtask

    logic [15:0] dw0, dw1, dw_or;
    logic        tz0, tz1, tz_and;
    int          ub, ob, lb, rb, lvb;

    initial begin
        i_rst_n = 1'b0;
        i_aud_bclk = 1'b1;
        i_aud_adclrck = 1'b1;
        i_aud_daclrck = 1'b1;
        i_aud_adcdat = 1'b0;
        i_adc_left_ready = 1'b1;
        i_adc_right_ready = 1'b1;
        i_dac_left_data = '0;
        i_dac_right_data = '0;
        i_dac_left_valid = 1'b0;
        i_dac_right_valid = 1'b0;

        // Reset state and ready release
        #100;
        check_val("rst_outs", all_outs, 64'd0);
        i_rst_n = 1'b1;
        #1;
        check_val("rdy_pre", {o_dac_left_ready, o_dac_right_ready}, 2'b00);
        @(posedge i_clk);
        #1;
        check_val("rdy_post", {o_dac_left_ready, o_dac_right_ready}, 2'b11);
        #100;
        align20();

        // RX with ready held high; TX idle so both halves underrun
        ub = uf_pulses; lb = left_q.size(); rb = right_q.size(); lvb = lv_cycles;
        half_frame(1'b0, 16'hA5C3, -10, dw0, tz0);
        half_frame(1'b1, 16'h0F0F, -10, dw1, tz1);
        #100;
        check_val("t1_left_n", left_q.size() - lb, 1);
        check_val("t1_left_d", left_q[lb], 16'hA5C3);
        check_val("t1_lv_cyc", lv_cycles - lvb, 1);
        check_val("t1_right_n", right_q.size() - rb, 1);
        check_val("t1_right_d", right_q[rb], 16'h0F0F);
        check_val("t1_dac0", {dw0, dw1, tz0, tz1}, {32'd0, 2'b11});
        check_val("t1_uf_n", uf_pulses - ub, 2);
        check_val("t1_uf_cnt", o_tx_underrun_cnt, STAT ? 8'd2 : 8'd0);

        // RX backpressure on left
        do_reset();
        i_adc_left_ready = 1'b0;
        ob = ov_pulses;
        half_frame(1'b0, 16'h1111, -10, dw0, tz0);
        half_frame(1'b1, 16'h0000, -10, dw0, tz0);
        half_frame(1'b0, 16'h2222, -10, dw0, tz0);
        half_frame(1'b1, 16'h0000, -10, dw0, tz0);
        #100;
        check_val("t2_hold_d", o_adc_left_data, 16'h1111);
        check_val("t2_hold_v", o_adc_left_valid, 1'b1);
        check_val("t2_ov_n", ov_pulses - ob, 1);
        check_val("t2_ov_cnt", o_rx_overrun_cnt, STAT ? 8'd1 : 8'd0);
        lb = left_q.size();
        i_adc_left_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check_val("t2_drop_v", o_adc_left_valid, 1'b0);
        check_val("t2_acc_n", left_q.size() - lb, 1);
        check_val("t2_acc_d", left_q[lb], 16'h1111);

        // TX serialisation
        do_reset();
        dac_write(1'b0, 16'h8001);
        dac_write(1'b1, 16'h7FFE);
        #1;
        check_val("t3_full", {o_dac_left_ready, o_dac_right_ready}, 2'b00);
        align20();
        ub = uf_pulses;
        half_frame(1'b0, 16'h0000, -10, dw0, tz0);
        half_frame(1'b1, 16'h0000, -10, dw1, tz1);
        check_val("t3_left_bits", dw0, 16'h8001);
        check_val("t3_right_bits", dw1, 16'h7FFE);
        check_val("t3_tails", {tz0, tz1}, 2'b11);
        check_val("t3_uf_n", uf_pulses - ub, 0);
        check_val("t3_rdy", {o_dac_left_ready, o_dac_right_ready}, 2'b11);

        // TX underrun over three frames
        do_reset();
        ub = uf_pulses;
        dw_or = '0;
        tz_and = 1'b1;
        for (int f = 0; f < 6; f++) begin
            half_frame(f[0], 16'hFFFF, -10, dw0, tz0);
            dw_or = dw_or | dw0;
            tz_and = tz_and & tz0;
        end
        #100;
        check_val("t4_dac0", {dw_or, tz_and}, {16'd0, 1'b1});
        check_val("t4_uf_n", uf_pulses - ub, 6);
        check_val("t4_uf_cnt", o_tx_underrun_cnt, STAT ? 8'd6 : 8'd0);

        // Reset in the middle of an RX shift
        do_reset();
        i_adc_left_ready = 1'b0;
        half_frame(1'b0, 16'h5555, -10, dw0, tz0);
        half_frame(1'b1, 16'h0000, -10, dw0, tz0);
        check_val("t5_pre_v", o_adc_left_valid, 1'b1);
        half_frame(1'b0, 16'h1234, 8, dw0, tz0);
        i_adc_left_ready = 1'b1;
        lb = left_q.size();
        rb = right_q.size();
        half_frame(1'b1, 16'hBEEF, -10, dw0, tz0);
        half_frame(1'b0, 16'hCAFE, -10, dw0, tz0);
        #100;
        check_val("t5_right_n", right_q.size() - rb, 1);
        check_val("t5_right_d", right_q[rb], 16'hBEEF);
        check_val("t5_left_n", left_q.size() - lb, 1);
        check_val("t5_left_d", left_q[lb], 16'hCAFE);
        half_frame(1'b1, 16'h0000, -10, dw0, tz0);

        // Underrun counter saturation
        do_reset();
        ub = uf_pulses;
        for (int f = 0; f < 300; f++) half_frame(f[0], 16'h0000, -10, dw0, tz0);
        #100;
        check_val("t6_uf_n", uf_pulses - ub, 300);
        check_val("t6_uf_sat", o_tx_underrun_cnt, STAT ? 8'd255 : 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
